// File: rtl/sys_panel_input_if.sv
// Board-pin side and processor side signals of the panel input front end.
// The processor-facing outputs keep the system top's SYS_* names.
interface sys_panel_input_if;
    logic       btn_load;
    logic [7:0] sw_pc;
    logic [7:0] sw_sel;
    logic       SYS_load;
    logic [7:0] SYS_pc_val;
    logic [7:0] SYS_output_sel;
    logic [7:0] load_count;

    modport master (
        output btn_load, sw_pc, sw_sel,
        input  SYS_load, SYS_pc_val, SYS_output_sel, load_count
    );

    modport slave (
        input  btn_load, sw_pc, sw_sel,
        output SYS_load, SYS_pc_val, SYS_output_sel, load_count
    );
endinterface

// File: rtl/sys_panel_input.sv
// Panel front end: synchronizes the switches, debounces the load button and
// issues one SYS_load strobe per accepted press, latching the PC switches.
module sys_panel_input #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic              SYS_clk,
    input logic              SYS_reset,
    sys_panel_input_if.slave pif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_m_q, btn_s_q;
    logic [7:0]    pc_m_q, pc_s_q;
    logic [7:0]    sel_m_q, sel_s_q;
    logic          load_q, load_d;
    logic [7:0]    pc_val_q, pc_val_d;
    logic [7:0]    count_q, count_d;

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            btn_m_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            pc_m_q   <= '0;
            pc_s_q   <= '0;
            sel_m_q  <= '0;
            sel_s_q  <= '0;
            load_q   <= 1'b0;
            pc_val_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            btn_m_q  <= pif.btn_load;
            btn_s_q  <= btn_m_q;
            pc_m_q   <= pif.sw_pc;
            pc_s_q   <= pc_m_q;
            sel_m_q  <= pif.sw_sel;
            sel_s_q  <= sel_m_q;
            load_q   <= load_d;
            pc_val_q <= pc_val_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_d   = 1'b0;
        pc_val_d = pc_val_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Accepted press: strobe and capture in the same edge
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    load_d   = 1'b1;
                    pc_val_d = pc_s_q;
                    count_d  = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (btn_s_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pif.SYS_load       = load_q;
    assign pif.SYS_pc_val     = pc_val_q;
    assign pif.SYS_output_sel = sel_s_q;
    assign pif.load_count     = count_q;
endmodule

// File: tb/tb_sys_panel_input.sv
// Directed bench for sys_panel_input (D=4) with a strobe scoreboard:
// each accepted press queues its strobe cycle, PC value and count.
module tb_sys_panel_input;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   strobes = 0;
    logic [7:0] exp_count = 8'd0;

    typedef struct {
        int         cyc;
        logic [7:0] pc;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sys_panel_input_if pif();

    sys_panel_input #(.DEBOUNCE_CYCLES(4)) dut (
        .SYS_clk  (clk),
        .SYS_reset(rst),
        .pif      (pif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (pif.SYS_load !== 1'b0) begin
            strobes++;
            chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("strobe_cycle", cyc, mon_e.cyc);
                chk("strobe_pc_val", 32'(pif.SYS_pc_val), 32'(mon_e.pc));
                chk("strobe_count", 32'(pif.load_count), 32'(mon_e.cnt));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_strobe(input logic [7:0] pc);
        exp_count = exp_count + 8'd1;
        sb.push_back('{cyc + 6, pc, exp_count});
    endtask

    task automatic press(input logic [7:0] pc, input int hold);
        pif.sw_pc = pc;
        step(2);
        pif.btn_load = 1'b1;
        expect_strobe(pc);
        step(hold);
        pif.btn_load = 1'b0;
        step(8);
    endtask

    task automatic bits(input logic [7:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            pif.btn_load = pat[i];
            step(1);
        end
    endtask

    initial begin
        rst = 1'b1;
        pif.btn_load = 1'b0;
        pif.sw_pc = 8'h00;
        pif.sw_sel = 8'hA5;

        // Reset: outputs held at zero, select appears 2 cycles after release
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_load", 32'(pif.SYS_load), 32'd0);
            chk("rst_pc_val", 32'(pif.SYS_pc_val), 32'd0);
            chk("rst_sel", 32'(pif.SYS_output_sel), 32'd0);
            chk("rst_count", 32'(pif.load_count), 32'd0);
        end
        rst = 1'b0;
        step(1);
        chk("sel_lat1", 32'(pif.SYS_output_sel), 32'h00);
        step(1);
        chk("sel_lat2", 32'(pif.SYS_output_sel), 32'hA5);

        // Clean press held 20 cycles, then a bouncy release
        pif.sw_pc = 8'h3C;
        step(2);
        pif.btn_load = 1'b1;
        expect_strobe(8'h3C);
        step(20);
        chk("clean_count", 32'(pif.load_count), 32'd1);
        chk("clean_pc_hold", 32'(pif.SYS_pc_val), 32'h3C);
        bits(8'b0010, 4);
        pif.btn_load = 1'b0;
        step(10);
        press(8'h81, 10);
        chk("relb_count", 32'(pif.load_count), 32'd2);
        chk("relb_pc", 32'(pif.SYS_pc_val), 32'h81);

        // Press bounce 1,1,0,1,0 then a held press
        pif.sw_pc = 8'hC7;
        step(2);
        bits(8'b11010, 5);
        pif.btn_load = 1'b1;
        expect_strobe(8'hC7);
        step(10);
        pif.btn_load = 1'b0;
        step(8);
        chk("pressb_count", 32'(pif.load_count), 32'd3);

        // Reset while in PRESS_WAIT with the button held throughout
        pif.sw_pc = 8'hE1;
        step(2);
        pif.btn_load = 1'b1;
        step(3);
        rst = 1'b1;
        step(2);
        chk("midrst_load", 32'(pif.SYS_load), 32'd0);
        chk("midrst_count", 32'(pif.load_count), 32'd0);
        chk("midrst_pc", 32'(pif.SYS_pc_val), 32'd0);
        rst = 1'b0;
        exp_count = 8'd0;
        expect_strobe(8'hE1);
        step(12);
        pif.btn_load = 1'b0;
        step(8);
        chk("midrst_after_count", 32'(pif.load_count), 32'd1);
        chk("midrst_after_pc", 32'(pif.SYS_pc_val), 32'hE1);

        // Counter wrap over 256 presses
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        exp_count = 8'd0;
        step(2);
        for (int i = 0; i < 256; i++) begin
            press(i[7:0], 8);
            if (i == 254) chk("wrap_ff", 32'(pif.load_count), 32'hFF);
            if (i == 255) chk("wrap_00", 32'(pif.load_count), 32'h00);
        end

        chk("total_strobes", strobes, 32'd260);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sys_panel_input.md
# sys_panel_input

Board-side front end for the MIPS system top: conditions the raw load push-button and the slide switches into the clean control inputs the processor consumes. It produces a single-cycle `SYS_load` strobe per debounced press, a PC value latched at that strobe, and a synchronized output-select bus. It sits between the FPGA pins and the `SYS_load` / `SYS_pc_val` / `SYS_output_sel` inputs of the system top.

## Interface

- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized-high samples needed to accept a press, and synchronized-low samples needed to accept a release. Legal range 2..2^20; counter width is `$clog2(DEBOUNCE_CYCLES)+1`.

- `SYS_clk`  in  1  sole clock; all flops are rising-edge.
- `SYS_reset`  in  1  synchronous reset, active-high.
- `btn_load`  in  1  raw asynchronous load push-button, active-high, bouncy.
- `sw_pc`  in  8  raw asynchronous PC-value switches.
- `sw_sel`  in  8  raw asynchronous output-select switches.
- `SYS_load`  out  1  one-cycle load strobe, registered.
- `SYS_pc_val`  out  8  PC value captured on each strobe, registered.
- `SYS_output_sel`  out  8  synchronized `sw_sel`, registered.
- `load_count`  out  8  number of strobes issued since reset, modulo 256.

## Operation

**Synchronizers**
- Each of `btn_load`, `sw_pc[7:0]` and `sw_sel[7:0]` passes through its own two-flop synchronizer, giving `btn_s`, `pc_s` and `sel_s`.
- `SYS_output_sel` is `sel_s`, with no debounce.
- Per-bit skew on multi-bit buses is accepted. Switches are required to be static around a press.

**FSM (4 states), counter `cnt`**
- IDLE:
  - `btn_s`=1 → PRESS_WAIT, `cnt`←1.
  - Otherwise stay, `cnt`←0.
- PRESS_WAIT:
  - `btn_s`=0 → IDLE, `cnt`←0 (bounce rejected, no strobe).
  - `btn_s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → PRESSED; in the same edge `SYS_load`←1, `SYS_pc_val`←`pc_s`, `load_count`←`load_count`+1, `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.
- PRESSED:
  - `btn_s`=0 → RELEASE_WAIT, `cnt`←1.
  - Otherwise stay.
- RELEASE_WAIT:
  - `btn_s`=1 → PRESSED, `cnt`←0 (release bounce; no new strobe).
  - `btn_s`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → IDLE, `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.

**Strobe and counter rules**
- `SYS_load` is 0 on every edge except the PRESS_WAIT→PRESSED edge. It is therefore exactly one cycle wide, and at most one strobe is issued per press/release cycle, however long the button is held.
- `SYS_pc_val` changes only on a strobe edge and holds between strobes.
- `load_count` wraps 255→0.

**Reset**
- Takes effect at the next edge regardless of state.
- State←IDLE, `cnt`←0.
- All synchronizer flops, `SYS_load`, `SYS_pc_val`, `SYS_output_sel` and `load_count` ← 0.
- Reset in PRESS_WAIT aborts the press: no strobe.
- A button still held after reset deasserts is treated as a fresh press and produces one strobe once it is debounced.

## Timing

- **Reset values:** every output is 0.
- **`SYS_output_sel` latency:** a `sw_sel` change set up before edge k appears after edge k+1 (2 cycles).
- **Press latency:**
  - `btn_load` rises before edge 0 and stays high.
  - `btn_s`=1 after edge 1.
  - FSM samples high at edges 2..D+1.
  - `SYS_load`=1 after edge D+1 and 0 after edge D+2.
  - Total D+2 cycles from raw edge to strobe, where D=`DEBOUNCE_CYCLES`.
- **Captured PC value:** `SYS_pc_val` is valid in the same cycle `SYS_load` is high and equals `pc_s` as sampled at edge D+1.
- **Release:** requires D consecutive low samples before a new press can start, so the minimum press-to-press spacing is about 2D+2 cycles.
- **Counter width:** `cnt` never exceeds D-1; no overflow.

## Test plan

All scenarios use D=4.

- **Reset:**
  - Stimulus: assert `SYS_reset` 3 cycles with `sw_sel`=8'hA5 and `btn_load`=0, then release.
  - Required: all outputs 0 during reset; `SYS_output_sel`=8'hA5 exactly 2 cycles after release.
- **Clean press:**
  - Stimulus: `sw_pc`=8'h3C, then `btn_load` high for 20 cycles.
  - Required: `SYS_load` high exactly 1 cycle, after edge 5 relative to the raw edge; `SYS_pc_val`=8'h3C in that cycle; `load_count`=1.
- **Press bounce:**
  - Stimulus: `btn_load` pattern 1,1,0,1,0 (one cycle each), then high.
  - Required: no strobe during the bounce; exactly one strobe 6 cycles after the final rise.
- **Release bounce:**
  - Stimulus: after a strobe, `btn_load` pattern 0,0,1,0 then low for 10 cycles, then a new clean press with `sw_pc`=8'h81.
  - Required: no strobe from the release bounce; the second press gives `SYS_pc_val`=8'h81 and `load_count`=2.
- **Reset mid-press:**
  - Stimulus: assert `SYS_reset` while in PRESS_WAIT, with the button held throughout.
  - Required: no strobe before reset; one strobe 6 cycles after reset release.
- **Wrap:**
  - Stimulus: 256 clean presses.
  - Required: `load_count` reads 8'hFF after press 255 and 8'h00 after press 256; exactly 256 strobes observed.
